// File: rtl/i2s_pkg.sv
// Shared constants and decode helpers for the I2S codec interface.
// The whole interface runs off one 10-bit free-running counter. The constants
// below are the counter bit positions and the counter values at which the
// RX/TX datapaths act.
package i2s_pkg;

  localparam int CNT_W     = 10;
  localparam int MCLK_BIT  = 1;
  localparam int SCLK_BIT  = 4;
  localparam int LRCLK_BIT = 9;
  localparam int SMPL_W    = 16;

  // The counter starts in the right slot, so the first (partial) frame after
  // reset carries no usable left word.
  localparam logic [CNT_W-1:0] CNT_RST = 10'h200;

  // Counter values of the SCLK rise that samples the last bit of each word.
  localparam logic [CNT_W-1:0] RX_LFT_DONE = 10'h20F;
  localparam logic [CNT_W-1:0] RX_RGT_DONE = 10'h00F;

  // Counter values of the SCLK fall that loads each word for transmission.
  // Loading one SCLK after the LRCLK edge gives the standard 1-bit delay.
  localparam logic [CNT_W-1:0] TX_LFT_LD = 10'h01F;
  localparam logic [CNT_W-1:0] TX_RGT_LD = 10'h21F;

  // Low counter bits at the cycle before SCLK rises / falls.
  localparam logic [SCLK_BIT:0] SCLK_RISE_PH = 5'h0F;
  localparam logic [SCLK_BIT:0] SCLK_FALL_PH = 5'h1F;

  // Action taken by the TX shift register in a given cycle.
  typedef enum logic [1:0] {
    TX_HOLD   = 2'd0,
    TX_LD_LFT = 2'd1,
    TX_LD_RGT = 2'd2,
    TX_SHIFT  = 2'd3
  } tx_op_e;

  // Map a counter value to the TX shift-register action. The two word-load
  // points are themselves SCLK falls, so they take priority over the shift.
  function automatic tx_op_e tx_op_decode(input logic [CNT_W-1:0] c);
    tx_op_e op;
    op = TX_HOLD;
    if (c == TX_LFT_LD) begin
      op = TX_LD_LFT;
    end else if (c == TX_RGT_LD) begin
      op = TX_LD_RGT;
    end else if (c[SCLK_BIT:0] == SCLK_FALL_PH) begin
      op = TX_SHIFT;
    end
    return op;
  endfunction

endpackage

// File: rtl/i2s_tx_ser.sv
// I2S transmit serializer: left/right holding registers, a 16-bit shift
// register and the SDin output. The load/shift strobes come from the
// top-level counter decode, so this block has no notion of frame timing.
module i2s_tx_ser
  import i2s_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_vld,
  input  logic [SMPL_W-1:0] lft_in,
  input  logic [SMPL_W-1:0] rght_in,
  input  logic              ld_lft,
  input  logic              ld_rgt,
  input  logic              shift,
  output logic              SDin
);

  logic [SMPL_W-1:0] hold_l;
  logic [SMPL_W-1:0] hold_r;
  logic [SMPL_W-1:0] tx_sr;

  // Capture a new stereo pair whenever tx_vld is high; there is no back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l <= '0;
      hold_r <= '0;
    end else if (tx_vld) begin
      hold_l <= lft_in;
      hold_r <= rght_in;
    end
  end

  // Load a held word at its slot start, otherwise shift MSB-first on SCLK falls.
  // A load coinciding with tx_vld takes the previous holding value.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr <= '0;
    end else if (ld_lft) begin
      tx_sr <= hold_l;
    end else if (ld_rgt) begin
      tx_sr <= hold_r;
    end else if (shift) begin
      tx_sr <= {tx_sr[SMPL_W-2:0], 1'b0};
    end
  end

  // After 15 shifts the LSB sits in the MSB and is held until the next load,
  // i.e. through the first SCLK rise of the following slot.
  assign SDin = tx_sr[SMPL_W-1];

endmodule

// File: rtl/i2s_codec_intf.sv
// I2S master between the audio codec and the sample datapath.
// A single free-running counter produces MCLK/SCLK/LRCLK directly from
// register bits and times every RX and TX action. Received words are
// deserialized here; transmission is delegated to i2s_tx_ser.
//
// Output stream: vld is a one-cycle pulse with no ready. In the vld cycle
// lft_chnnl/rght_chnnl hold a complete new stereo pair; the consumer must take
// it then. rght_chnnl stays stable for a full frame, lft_chnnl for 512 cycles.
module i2s_codec_intf
  import i2s_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              SDout,
  input  logic              tx_vld,
  input  logic [SMPL_W-1:0] lft_in,
  input  logic [SMPL_W-1:0] rght_in,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDin,
  output logic              vld,
  output logic [SMPL_W-1:0] lft_chnnl,
  output logic [SMPL_W-1:0] rght_chnnl
);

  logic [CNT_W-1:0]  cnt;
  logic              sclk_rise;
  logic              rx_lft_done;
  logic              rx_rgt_done;
  logic [SMPL_W-1:0] rx_sr;
  logic [SMPL_W-1:0] rx_word;
  logic              armed;
  tx_op_e            tx_op;
  logic              tx_ld_lft;
  logic              tx_ld_rgt;
  logic              tx_shift;

  // Free-running frame counter; wraps every 1024 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CNT_RST;
    end else begin
      cnt <= cnt + 10'd1;
    end
  end

  // Clocks come straight from counter flops, so they cannot glitch.
  assign MCLK  = cnt[MCLK_BIT];
  assign SCLK  = cnt[SCLK_BIT];
  assign LRCLK = cnt[LRCLK_BIT];

  // Decodes are one cycle ahead of the corresponding SCLK edge on the pins.
  assign sclk_rise   = (cnt[SCLK_BIT:0] == SCLK_RISE_PH);
  assign rx_lft_done = (cnt == RX_LFT_DONE);
  assign rx_rgt_done = (cnt == RX_RGT_DONE);

  // Word as it will look after this cycle's shift; used to publish a channel
  // in the same edge that samples its LSB.
  assign rx_word = {rx_sr[SMPL_W-2:0], SDout};

  // Sample SDout on every SCLK rise, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr <= '0;
    end else if (sclk_rise) begin
      rx_sr <= rx_word;
    end
  end

  // Publish completed words. vld fires with the right word, but only once a
  // right-word boundary has been seen since reset, which skips the partial
  // frame that reset always lands in.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_chnnl  <= '0;
      rght_chnnl <= '0;
      vld        <= 1'b0;
      armed      <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (rx_lft_done) begin
        lft_chnnl <= rx_word;
      end
      if (rx_rgt_done) begin
        rght_chnnl <= rx_word;
        vld        <= armed;
        armed      <= 1'b1;
      end
    end
  end

  // TX shift-register action for this cycle.
  assign tx_op     = tx_op_decode(cnt);
  assign tx_ld_lft = (tx_op == TX_LD_LFT);
  assign tx_ld_rgt = (tx_op == TX_LD_RGT);
  assign tx_shift  = (tx_op == TX_SHIFT);

  i2s_tx_ser u_tx_ser (
    .clk    (clk),
    .rst    (rst),
    .tx_vld (tx_vld),
    .lft_in (lft_in),
    .rght_in(rght_in),
    .ld_lft (tx_ld_lft),
    .ld_rgt (tx_ld_rgt),
    .shift  (tx_shift),
    .SDin   (SDin)
  );

endmodule

// File: tb/tb_i2s_codec_intf.sv
// Bench for i2s_codec_intf: codec model on SDout, SDin decoder, RX/TX
// expected queues with monitors, and directed timing/reset/clock checks.
module tb_i2s_codec_intf;

  logic        clk;
  logic        rst;
  logic        SDout;
  logic        tx_vld;
  logic [15:0] lft_in;
  logic [15:0] rght_in;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        SDin;
  logic        vld;
  logic [15:0] lft_chnnl;
  logic [15:0] rght_chnnl;

  int n_compared = 0;
  int n_mismatch = 0;

  logic [31:0] rx_exp_q[$];
  logic [31:0] tx_exp_q[$];

  i2s_codec_intf dut (
    .clk       (clk),
    .rst       (rst),
    .SDout     (SDout),
    .tx_vld    (tx_vld),
    .lft_in    (lft_in),
    .rght_in   (rght_in),
    .MCLK      (MCLK),
    .SCLK      (SCLK),
    .LRCLK     (LRCLK),
    .SDin      (SDin),
    .vld       (vld),
    .lft_chnnl (lft_chnnl),
    .rght_chnnl(rght_chnnl)
  );

  // ---------------- clock / reset / timebase ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [9:0] m_cnt = 10'h200;
  int         n_cyc = 0;
  int         cyc_total = 0;

  always @(posedge clk) begin
    cyc_total <= cyc_total + 1;
    if (rst) begin
      m_cnt <= 10'h200;
      n_cyc <= 0;
    end else begin
      m_cnt <= m_cnt + 10'd1;
      n_cyc <= n_cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cnt(input logic [9:0] v);
    for (int i = 0; i < 2048; i++) begin
      @(posedge clk);
      #1;
      if (m_cnt == v) return;
    end
    n_compared++;
    n_mismatch++;
    $display("FAIL wait_cnt: counter value 0x%0h not reached", v);
  endtask

  // ---------------- codec model (ADC side) ----------------
  logic [15:0] c_l;
  logic [15:0] c_r;
  logic [15:0] c_w;
  logic        c_lr;
  logic        c_prev_sclk;
  int          c_k;
  int          c_halves;

  always @(negedge clk) begin
    if (rst) begin
      c_lr        = 1'b1;
      c_prev_sclk = 1'b0;
      c_k         = 0;
      c_halves    = 0;
      SDout       = 1'b0;
    end else begin
      if (c_prev_sclk && !SCLK) begin
        if (LRCLK != c_lr) begin
          c_w   = c_lr ? c_r : c_l;
          SDout = c_w[0];
          if (!LRCLK && c_halves >= 2) rx_exp_q.push_back({c_l, c_r});
          c_halves++;
          c_lr = LRCLK;
          c_k  = 0;
        end else begin
          c_k++;
          c_w = c_lr ? c_r : c_l;
          if (c_k <= 15) SDout = c_w[16-c_k];
          else SDout = 1'b0;
        end
      end
      c_prev_sclk = SCLK;
    end
  end

  // ---------------- RX monitor ----------------
  int  vld_cnt = 0;
  int  last_vld = 0;
  bit  last_ok = 0;
  bit  first_pend = 1;
  logic [31:0] rx_e;

  always @(negedge clk) begin
    if (rst) begin
      rx_exp_q.delete();
      first_pend = 1;
      last_ok    = 0;
      vld_cnt    = 0;
    end else if (vld) begin
      vld_cnt++;
      if (first_pend) begin
        chk("first_vld_cycle", 32'(n_cyc), 32'd1552);
        first_pend = 0;
      end
      if (last_ok) chk("vld_period", 32'(cyc_total - last_vld), 32'd1024);
      last_vld = cyc_total;
      last_ok  = 1;
      if (rx_exp_q.size() == 0) begin
        n_compared++;
        n_mismatch++;
        $display("FAIL rx_unexpected_vld: vld with no expected pair at n=%0d", n_cyc);
      end else begin
        rx_e = rx_exp_q.pop_front();
        chk("rx_left", 32'(lft_chnnl), 32'(rx_e[31:16]));
        chk("rx_right", 32'(rght_chnnl), 32'(rx_e[15:0]));
      end
    end
  end

  // ---------------- TX monitor (DAC side decoder) ----------------
  logic [15:0] t_sr;
  logic [15:0] t_l;
  logic        t_lr;
  logic        t_lok;
  logic        t_prev;
  logic [31:0] tx_e;

  always @(negedge clk) begin
    if (rst) begin
      tx_exp_q.delete();
      t_sr   = '0;
      t_l    = '0;
      t_lr   = 1'b1;
      t_lok  = 1'b0;
      t_prev = 1'b0;
    end else begin
      if (!t_prev && SCLK) begin
        t_sr = {t_sr[14:0], SDin};
        if (LRCLK != t_lr) begin
          if (LRCLK) begin
            t_l   = t_sr;
            t_lok = 1'b1;
          end else if (t_lok && tx_exp_q.size() > 0) begin
            tx_e = tx_exp_q.pop_front();
            chk("tx_left", 32'(t_l), 32'(tx_e[31:16]));
            chk("tx_right", 32'(t_sr), 32'(tx_e[15:0]));
          end
          t_lr = LRCLK;
        end
      end
      t_prev = SCLK;
    end
  end

  // ---------------- directed sequence ----------------
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mclk"},  32'(MCLK),       32'd0);
    chk({tag, "_sclk"},  32'(SCLK),       32'd0);
    chk({tag, "_lrclk"}, 32'(LRCLK),      32'd1);
    chk({tag, "_sdin"},  32'(SDin),       32'd0);
    chk({tag, "_vld"},   32'(vld),        32'd0);
    chk({tag, "_lft"},   32'(lft_chnnl),  32'd0);
    chk({tag, "_rght"},  32'(rght_chnnl), 32'd0);
  endtask

  logic p_m, p_s, p_l;
  int   mc, sc, lc;

  initial begin
    rst     = 1'b1;
    tx_vld  = 1'b0;
    lft_in  = '0;
    rght_in = '0;
    c_l     = 16'h8001;
    c_r     = 16'h7FFE;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // TX: new pair issued just after the right word completed decoding
    wait_cnt(10'h012);
    lft_in  = 16'hA5A5;
    rght_in = 16'h1234;
    tx_vld  = 1'b1;
    tx_exp_q.push_back({16'hA5A5, 16'h1234});
    @(posedge clk);
    #1 tx_vld = 1'b0;
    wait_cnt(10'h01F);
    @(negedge clk);
    chk("tx_before_msb", 32'(SDin), 32'd0);
    @(negedge clk);
    chk("tx_msb_at_020", 32'(SDin), 32'd1);

    // Collision: tx_vld in the cycle the left word is loaded
    wait_cnt(10'h01F);
    lft_in  = 16'h0F0F;
    rght_in = 16'hF00F;
    tx_vld  = 1'b1;
    tx_exp_q.push_back({16'hA5A5, 16'hF00F});
    tx_exp_q.push_back({16'h0F0F, 16'hF00F});
    @(posedge clk);
    #1 tx_vld = 1'b0;

    for (int i = 0; i < 5000 && tx_exp_q.size() != 0; i++) @(posedge clk);
    chk("tx_drain", 32'(tx_exp_q.size()), 32'd0);

    // Clock ratios over 4 frames
    mc = 0; sc = 0; lc = 0;
    @(negedge clk);
    p_m = MCLK; p_s = SCLK; p_l = LRCLK;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (MCLK && !p_m) mc++;
      if (SCLK && !p_s) sc++;
      if (LRCLK && !p_l) lc++;
      if (LRCLK != p_l) chk("lr_on_sclk_fall", {30'd0, p_s, SCLK}, 32'd2);
      p_m = MCLK; p_s = SCLK; p_l = LRCLK;
    end
    chk("mclk_periods", 32'(mc), 32'd1024);
    chk("sclk_periods", 32'(sc), 32'd128);
    chk("lrclk_periods", 32'(lc), 32'd4);

    // Mid-frame reset with a new codec pattern
    wait_cnt(10'h105);
    rst = 1'b1;
    c_l = 16'h4C3A;
    c_r = 16'hB1C5;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 1'b0;

    for (int i = 0; i < 1552 + 1024 + 200 && vld_cnt < 2; i++) @(posedge clk);
    chk("vld_after_midrst", 32'(vld_cnt), 32'd2);
    repeat (50) @(posedge clk);
    chk("rx_drain", 32'(rx_exp_q.size()), 32'd0);
    chk("tx_idle", 32'(tx_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/i2s_codec_intf.md
# i2s_codec_intf

- Bidirectional I2S master interface between the audio codec and the sample-processing datapath.
- It generates MCLK, SCLK and LRCLK from the system clock.
- It deserializes the codec's SDout into signed 16-bit left/right samples with a one-cycle vld pulse per frame; this is the stream consumed by the LED driver and equalizer.
- It serializes processed left/right samples back onto SDin.

## Interface
- No parameters; all constants live in i2s_pkg.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- SDout  in  1  serial data from codec ADC.
- tx_vld  in  1  captures lft_in/rght_in into the TX holding registers.
- lft_in  in  16  signed left sample to transmit.
- rght_in  in  16  signed right sample to transmit.
- MCLK  out  1  codec master clock, clk/4.
- SCLK  out  1  bit clock, clk/32.
- LRCLK  out  1  frame clock, clk/1024; low = left slot, high = right slot.
- SDin  out  1  serial data to codec DAC.
- vld  out  1  one-cycle pulse; lft_chnnl/rght_chnnl hold a new stereo pair.
- lft_chnnl  out  16  signed received left sample.
- rght_chnnl  out  16  signed received right sample.

## Operation
- **Clock generation**
  - 10-bit free-running counter cnt; reset value 0x200, increments every clk, wraps 0x3FF→0x000.
  - MCLK = cnt[1], SCLK = cnt[4], LRCLK = cnt[9], taken directly from register bits, so the outputs are glitch-free.
  - Each LRCLK half contains 16 SCLK periods, i.e. 16 bits per channel in standard I2S format with a 1-bit delay.
- **Event decodes**
  - sclk_rise = (cnt[4:0]==0x0F).
  - sclk_fall = (cnt[4:0]==0x1F).
- **RX path**
  - On every sclk_rise, 16-bit shift register rx_sr shifts left and takes SDout into the LSB.
  - At cnt==0x20F (first rise of the high half), rx_sr holds the complete left word; lft_chnnl is loaded next cycle.
  - At cnt==0x00F (first rise of the low half), rx_sr holds the complete right word; rght_chnnl is loaded next cycle.
  - vld is asserted in that same cycle (cnt==0x010) only if the armed flag is set.
  - armed resets to 0 and is set at the first cnt==0x00F event after reset, so the first frame after reset (partial, with a garbage left word) never pulses vld.
- **TX path**
  - tx_vld loads the left/right holding registers in any cycle. If tx_vld coincides with a shift-register load, the shift register takes the old holding value.
  - At cnt==0x01F, the TX shift register loads the left holding value.
  - At cnt==0x21F, the TX shift register loads the right holding value.
  - At every other sclk_fall, the TX shift register shifts left and fills the LSB with 0.
  - SDin = tx_sr[15]. The MSB appears one SCLK after the LRCLK edge; the LSB is held through the first rise of the following half.
- **Reset**
  - Reset values: cnt=0x200, so LRCLK=1, SCLK=0, MCLK=0.
  - Also cleared to 0: SDin, vld, lft_chnnl, rght_chnnl, rx_sr, tx_sr, holding registers and armed.
  - Reset asserted mid-frame aborts all in-flight words. The armed sequence restarts from scratch.

## Timing
- Frame period is 1024 clk.
- Outside reset, vld pulses exactly once per frame, at cnt==0x010.
- lft_chnnl and rght_chnnl are stable from the vld cycle until the next left or right update:
  - the next left update is 512 cycles later;
  - rght_chnnl is valid for 1024 cycles.
- Counting the first cycle after reset release as n=0:
  - the first armed event is at n=527;
  - the first vld is at n=1552.
- RX latency: the right LSB is sampled on the rise at cnt 0x00F; the sample is visible on the outputs 1 clk later.
- TX latency: a held sample reaches the SDin MSB at the next cnt==0x020 (left) or 0x220 (right).

## Structure
- i2s_pkg holds:
  - CNT_W=10, CNT_RST=10'h200, MCLK_BIT=1, SCLK_BIT=4, LRCLK_BIT=9, SMPL_W=16;
  - decode constants RX_LFT_DONE=0x20F, RX_RGT_DONE=0x00F, TX_LFT_LD=0x01F, TX_RGT_LD=0x21F.
- One sub-module, i2s_tx_ser, contains the TX holding registers, shift register and SDin. The counter, decodes and RX path stay in the top level.

## Test plan
- **Reset values:** hold rst for 5 cycles → MCLK=0, SCLK=0, LRCLK=1, SDin=0, vld=0, channels=0. The first vld occurs exactly 1552 cycles after release.
- **RX loopback:** codec model drives left=0x8001, right=0x7FFE, changing on SCLK falls with 1-bit delay → at each vld, lft_chnnl=0x8001 and rght_chnnl=0x7FFE; the vld pulse is exactly 1 cycle, with a 1024-cycle period.
- **TX:** tx_vld with lft_in=0xA5A5, rght_in=0x1234 → a monitor sampling SDin on SCLK rises decodes left 0xA5A5 and right 0x1234 in the next frame. The MSB appears at cnt 0x020.
- **Mid-load collision:** tx_vld with new data at cnt==0x01F → the current frame transmits the old left word; the new word goes out in the following frame.
- **Mid-frame reset:** assert rst at cnt=0x105 → all outputs return to reset values next cycle. No vld occurs until 1552 cycles after release.
- **Clock ratios:** over 4 frames, count edges → 256 MCLK, 32 SCLK and 1 LRCLK periods per frame. LRCLK only toggles in the same cycle SCLK falls.
